// File: rtl/fifo_reader_if.sv
// +-----------------------------------------------------------------------------
// | Module      : fifo_reader_if
// | Description : FIFO read port plus valid/ready output stream of fifo_reader.
// | Revision    : 1.0  initial release
// +-----------------------------------------------------------------------------
`default_nettype none

interface fifo_reader_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  r_en;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;

   modport master (
      input  fifo_empty, fifo_data, m_ready,
      output r_en, m_valid, m_data
   );

   modport slave (
      output fifo_empty, fifo_data, m_ready,
      input  r_en, m_valid, m_data
   );
endinterface

`default_nettype wire

// File: rtl/fifo_reader.sv
// +-----------------------------------------------------------------------------
// | Module      : fifo_reader
// | Description : Drains a 1-cycle-latency FIFO into a registered valid/ready
// |               stream through a 2-entry buffer. Optional FIFO_READER_CNT_EN
// |               adds the rd_count delivered-word counter port.
// | Revision    : 1.0  initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module fifo_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  wire logic          clk,
   input  wire logic          rst,
   input  wire logic          enable,
   fifo_reader_if.master      bus,
   output logic               busy
`ifdef FIFO_READER_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] rd_count
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            occ_q, occ_d;
   logic [1:0]            pend_q, pend_d;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] tail_q, tail_d;
   logic                  valid_q;
   logic                  busy_q;

   logic                  pop;
   logic                  capture;
   logic                  rd_issue;
   logic [2:0]            occ_sum;

   assign pop     = valid_q && bus.m_ready;
   assign capture = pend_q[0];
   // pop implies occ>=1, so the 3-bit sum never underflows
   assign occ_sum = {1'b0, occ_q} + {1'b0, pend_q} - {2'b00, pop};

   assign rd_issue = !rst && (state_q == S_RUN) && !bus.fifo_empty && (occ_sum <= 3'd1);

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      occ_d   = occ_sum[1:0];
      pend_d  = {1'b0, rd_issue};

      if (pop) begin
         if (occ_q == 2'd2) begin
            head_d = tail_q;
            if (capture) begin
               tail_d = bus.fifo_data;
            end
         end else if (capture) begin
            head_d = bus.fifo_data;
         end
      end else if (capture) begin
         if (occ_q == 2'd0) begin
            head_d = bus.fifo_data;
         end else begin
            tail_d = bus.fifo_data;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (enable) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (!enable) begin
               state_d = ((occ_sum != 3'd0) || rd_issue) ? S_DRAIN : S_IDLE;
            end
         end
         S_DRAIN: begin
            if (enable) begin
               state_d = S_RUN;
            end else if (occ_sum == 3'd0) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         occ_q   <= 2'd0;
         pend_q  <= 2'd0;
         head_q  <= '0;
         tail_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         occ_q   <= occ_d;
         pend_q  <= pend_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         valid_q <= (occ_d != 2'd0);
         busy_q  <= (state_d != S_IDLE);
      end
   end

   assign bus.r_en    = rd_issue;
   assign bus.m_valid = valid_q;
   assign bus.m_data  = head_q;
   assign busy        = busy_q;

`ifdef FIFO_READER_CNT_EN
   logic [CNT_WIDTH-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (pop) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign rd_count = cnt_q;
`else
   localparam int UNUSED_CNT_WIDTH = CNT_WIDTH;
`endif

   a_occ_max: assert property (@(posedge clk) disable iff (rst) occ_q <= 2'd2);

endmodule

`default_nettype wire

// File: tb/tb_fifo_reader.sv
// +-----------------------------------------------------------------------------
// | Module      : tb_fifo_reader
// | Description : Randomized bench for fifo_reader against a queue-based model.
// | Revision    : 1.0  initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_fifo_reader;

   localparam int DW = 8;
`ifdef FIFO_READER_CNT_EN
   localparam int CW = 4;
`endif

   logic clk = 1'b0;
   logic rst;
   logic enable;
   logic busy;
`ifdef FIFO_READER_CNT_EN
   logic [CW-1:0] rd_count;
`endif

   fifo_reader_if #(.DATA_WIDTH(DW)) bus ();

   fifo_reader #(
      .DATA_WIDTH (DW)
`ifdef FIFO_READER_CNT_EN
      ,
      .CNT_WIDTH  (CW)
`endif
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .bus      (bus),
      .busy     (busy)
`ifdef FIFO_READER_CNT_EN
      ,
      .rd_count (rd_count)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: words held by the reader, in delivery order
   logic [DW-1:0] mbuf[$];
   logic [DW-1:0] fifo_q[$];
   int            mpend;
   logic [DW-1:0] mpend_word;
   logic [DW-1:0] mlast;
   int            mstate;
   int            mcnt;

   bit            prev_rst;
   bit            prev_en;
   bit            prev_pop;
   bit            prev_exp_ren;
   bit            prev_dut_ren;
   logic [DW-1:0] wnext;
   logic [DW-1:0] winc;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic step(input bit nrst, input bit nen, input bit nrdy, input int npush);
      int  held;
      bit  exp_valid;
      bit  exp_pop;
      bit  exp_ren;
      @(negedge clk);
      if (prev_rst) begin
         mbuf.delete();
         mpend  = 0;
         mstate = 0;
         mlast  = '0;
         mcnt   = 0;
      end else begin
         if (prev_pop) begin
            void'(mbuf.pop_front());
            mcnt++;
         end
         if (mpend != 0) begin
            mbuf.push_back(mpend_word);
         end
         mpend = prev_exp_ren ? 1 : 0;
         held  = mbuf.size() + mpend;
         case (mstate)
            0: mstate = prev_en ? 1 : 0;
            1: if (!prev_en) mstate = (held != 0) ? 2 : 0;
            default: mstate = prev_en ? 1 : ((held == 0) ? 0 : 2);
         endcase
         if (mbuf.size() != 0) begin
            mlast = mbuf[0];
         end
      end
      if (prev_dut_ren && fifo_q.size() != 0) begin
         bus.fifo_data = fifo_q.pop_front();
      end
      if (mpend != 0) begin
         mpend_word = bus.fifo_data;
      end

      rst         = nrst;
      enable      = nen;
      bus.m_ready = nrdy;
      for (int i = 0; i < npush; i++) begin
         if (fifo_q.size() < 16) begin
            fifo_q.push_back(wnext);
            wnext = wnext + winc;
         end
      end
      bus.fifo_empty = (fifo_q.size() == 0);

      #1;
      exp_valid = (mbuf.size() != 0);
      exp_pop   = exp_valid && nrdy;
      exp_ren   = !nrst && (mstate == 1) && (fifo_q.size() != 0)
                  && ((mbuf.size() + mpend - (exp_pop ? 1 : 0)) <= 1);

      check_eq("r_en",    32'(bus.r_en),    32'(exp_ren));
      check_eq("m_valid", 32'(bus.m_valid), 32'(exp_valid));
      check_eq("m_data",  32'(bus.m_data),  32'(exp_valid ? mbuf[0] : mlast));
      check_eq("busy",    32'(busy),        32'(mstate != 0));
`ifdef FIFO_READER_CNT_EN
      check_eq("rd_count", 32'(rd_count), 32'(mcnt % (1 << CW)));
`endif

      prev_rst     = nrst;
      prev_en      = nen;
      prev_pop     = exp_pop;
      prev_exp_ren = exp_ren;
      prev_dut_ren = bus.r_en;
   endtask

   int p_en[4]   = '{90, 70, 95, 60};
   int p_rdy[4]  = '{90, 40, 100, 20};
   int p_push[4] = '{50, 70, 100, 30};

   initial begin
      rst            = 1'b1;
      enable         = 1'b0;
      bus.m_ready    = 1'b0;
      bus.fifo_data  = '0;
      bus.fifo_empty = 1'b1;
      prev_rst       = 1'b1;
      prev_en        = 1'b0;
      prev_pop       = 1'b0;
      prev_exp_ren   = 1'b0;
      prev_dut_ren   = 1'b0;
      mpend          = 0;
      mpend_word     = '0;
      mlast          = '0;
      mstate         = 0;
      mcnt           = 0;

      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);

      // three-word stream with a free-running consumer
      wnext = 8'h11;
      winc  = 8'h11;
      step(0, 0, 0, 3);
      repeat (5) step(0, 1, 1, 0);
      repeat (4) step(0, 0, 1, 0);

      // backpressure: eight words against a stalled consumer, then release
      wnext = 8'hA0;
      winc  = 8'h01;
      step(0, 0, 0, 8);
      repeat (6)  step(0, 1, 0, 0);
      repeat (10) step(0, 1, 1, 0);
      repeat (4)  step(0, 0, 1, 0);

      winc = 8'h35;
      for (int ph = 0; ph < 4; ph++) begin
         for (int c = 0; c < 600; c++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < p_en[ph]),
                 ($urandom_range(0, 99) < p_rdy[ph]),
                 ($urandom_range(0, 99) < p_push[ph]) ? int'($urandom_range(1, 2)) : 0);
         end
      end

      repeat (6) step(0, 0, 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
